// File: rtl/tt_eval_pkg.sv
// Shared widths and defaults for the truth-table evaluator.
package tt_eval_pkg;
  localparam int N_IN_DEF  = 3;
  localparam int N_OUT_DEF = 3;
  localparam int TT_ROWS   = 1 << N_IN_DEF;

  typedef logic [N_OUT_DEF-1:0] tt_row_t;

  function automatic int tt_idx_w(input int n_in);
    return n_in;
  endfunction

  function automatic int tt_row_w(input int n_out);
    return n_out;
  endfunction

  function automatic int tt_rows(input int n_in);
    return 1 << n_in;
  endfunction
endpackage

// File: rtl/tt_eval_table.sv
// 2^N_IN x N_OUT truth-table storage: one write port, one combinational read port.
module tt_eval_table
  import tt_eval_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [tt_idx_w(N_IN)-1:0]     cfg_addr,
  input  logic [tt_row_w(N_OUT)-1:0]    cfg_data,
  input  logic [tt_idx_w(N_IN)-1:0]     rd_addr,
  output logic [tt_row_w(N_OUT)-1:0]    rd_data
);
  localparam int ROWS = tt_rows(N_IN);

  logic [ROWS-1:0][N_OUT-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mem           <= '0;
    else if (cfg_we) mem[cfg_addr] <= cfg_data;
  end

  // Read is taken before the edge, so a same-cycle write is seen only by later lookups.
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tt_eval_pipe.sv
// Two-stage programmable truth-table evaluator with valid/ready flow control.
// Optional completed-evaluation counter: define TT_EVAL_CNT_EN.
module tt_eval_pipe
  import tt_eval_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
`ifdef TT_EVAL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f
`ifdef TT_EVAL_CNT_EN
  , output logic [CNT_W-1:0] eval_cnt
`endif
);
  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 (output) occupied
  logic [2:1]      vld_pipe;
  logic [N_IN-1:0] s1_x;
  logic [N_OUT-1:0] rd_data;
  logic            s1_valid, s2_adv;

  assign s1_valid  = vld_pipe[1];
  assign out_valid = vld_pipe[2];
  assign s2_adv    = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;

  tt_eval_table #(.N_IN(N_IN), .N_OUT(N_OUT)) u_table (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_addr  (s1_x),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_x     <= '0;
      f        <= '0;
    end else begin
      // in_ready with S1 full implies S1 drains this cycle, so S1 simply reloads.
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_x <= x;
      end
      if (s2_adv) begin
        vld_pipe[2] <= s1_valid;
        if (s1_valid) f <= rd_data;
      end
    end
  end

`ifdef TT_EVAL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         eval_cnt <= '0;
    else if (out_valid && out_ready) eval_cnt <= eval_cnt + CNT_W'(1);
  end
`endif
endmodule
